unstripe_4to1: RTL and testbench
================================

UNSTRIPE_4TO1 -- requirements
Module: unstripe_4to1

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_data0..in_data3  input  8 each  lane 0..3 byte.
REQ-004 SHALL have ports: in_valid0..in_valid3  input  1 each  lane 0..3 byte valid.
REQ-005 SHALL have port: in_ready  output  1  group buffer can accept a 4-lane group.
REQ-006 SHALL have port: out_data  output  8  serialized byte.
REQ-007 SHALL have port: out_valid  output  1  out_data valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts out_data.
REQ-009 SHALL have port: skew_err  output  1  sticky lane-skew flag.

Function
REQ-010 SHALL accept a group on a rising edge only when in_valid0..3 are all 1 and in_ready is 1.
REQ-011 SHALL store accepted groups in a 2-entry FIFO of 32-bit groups; count range 0..2.
REQ-012 SHALL drive in_ready = 1 when count < 2, combinationally from count only, with no same-cycle bypass at full.
REQ-013 SHALL serialize the head group in lane order 0,1,2,3, one byte per output transfer.
REQ-014 SHALL use output FSM states IDLE, L0, L1, L2, L3.
- IDLE -> L0 when count > 0.
- Lk -> Lk+1 on out_valid & out_ready.
- L3 -> L0 on transfer if another group is present, otherwise L3 -> IDLE.
REQ-015 SHALL register out_valid = 1 in L0..L3 and out_data = head byte of the current lane.
REQ-016 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL pop the head group on the L3 transfer edge.
REQ-018 SHALL have latency of 1 cycle: a group accepted at edge N into an empty FIFO gives out_valid = 1 with lane-0 byte after edge N+1.
REQ-019 SHALL reach full throughput of 4 bytes per 4 cycles with out_ready held at 1, with no idle cycle between groups.
REQ-020 SHALL update count correctly when push and pop occur on the same edge: count unchanged, write and read pointers both advance, and pointers wrap modulo 2.
REQ-021 SHALL set skew_err to 1 when in_ready = 1 and in_valid0..3 are neither all 0 nor all 1; that cycle accepts nothing.
REQ-022 SHALL hold skew_err at 1 until reset.

Reset
REQ-023 SHALL, on reset = 0 (asynchronous), immediately clear count, pointers and FSM (to IDLE), and drive out_valid = 0, out_data = 8'h00, skew_err = 0; in_ready then reads 1.
REQ-024 SHALL discard any partially serialized group when reset asserts mid-operation; after release, output resumes only with newly accepted groups.
REQ-025 SHALL treat reset deassertion synchronously in effect: the first state update occurs on the first rising clk edge with reset = 1.

Configuration
REQ-026 SHALL use macro UNSTRIPE_SKEW_CHECK_EN to select skew checking.
- Defined: skew detection per REQ-021/022.
- Undefined: skew_err is tied to 0, and a cycle with partial valids is simply not accepted.

Verification
REQ-027 SHALL cover single group: lanes 8'hA0,8'hA1,8'hA2,8'hA3 all valid, out_ready = 1 -> out_data A0,A1,A2,A3 on 4 consecutive cycles starting 1 cycle after accept; out_valid then 0.
REQ-028 SHALL cover back-pressure: out_ready = 0 for 3 cycles during lane 1 -> out_data holds A1 with out_valid = 1; sequence then continues with A2,A3 and no byte is lost.
REQ-029 SHALL cover full: three groups offered back-to-back with out_ready = 0 -> first two accepted, in_ready = 0 after count = 2; the third is accepted only after the first group's L3 pop.
REQ-030 SHALL cover skew (macro defined): in_valid = 4'b0101 with in_ready = 1 -> skew_err = 1 next cycle, nothing accepted, skew_err stays 1 until reset; with the macro undefined, skew_err stays 0.
REQ-031 SHALL cover mid-reset: reset asserted during L2 of group A -> out_valid = 0 and out_data = 8'h00 immediately; after release, group B bytes are output with no remnant of A.

Source files
------------

// File: rtl/unstripe_4to1.sv
// unstripe_4to1: collects 4-lane byte groups into a 2-entry group FIFO and
// serializes each group onto a single byte stream in lane order 0,1,2,3.
// Optional feature macro: UNSTRIPE_SKEW_CHECK_EN
//   defined   -> skew_err latches when lanes present partial valids
//   undefined -> skew_err is tied to 0
module unstripe_4to1 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic [7:0] in_data3,
    input  logic       in_valid0,
    input  logic       in_valid1,
    input  logic       in_valid2,
    input  logic       in_valid3,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       skew_err
);

    typedef enum logic [2:0] {IDLE, L0, L1, L2, L3} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [7:0]  out_data_reg, out_data_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] mem [2];

    logic [3:0]  valids;
    logic [31:0] in_group;
    logic [31:0] head;
    logic        push, pop, xfer;

    assign valids   = {in_valid3, in_valid2, in_valid1, in_valid0};
    assign in_group = {in_data3, in_data2, in_data1, in_data0};

    // Ready depends only on occupancy; a full FIFO never accepts, even if
    // a pop happens on the same edge.
    assign in_ready = (count_reg != 2'd2);
    assign push     = in_ready & (&valids);
    assign xfer     = out_valid_reg & out_ready;
    assign head     = mem[rd_ptr_reg];

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;

    // Group storage: two words kept in flops, written at the write pointer.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= in_group;
    end

    // Output FSM next state; the output byte is computed from the state being
    // entered so out_data/out_valid come straight from registers.
    always_comb begin
        state_next    = state_reg;
        out_data_next = out_data_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != 2'd0) begin
                    state_next    = L0;
                    out_data_next = head[7:0];
                end
            end
            L0: begin
                if (xfer) begin
                    state_next    = L1;
                    out_data_next = head[15:8];
                end
            end
            L1: begin
                if (xfer) begin
                    state_next    = L2;
                    out_data_next = head[23:16];
                end
            end
            L2: begin
                if (xfer) begin
                    state_next    = L3;
                    out_data_next = head[31:24];
                end
            end
            L3: begin
                if (xfer) begin
                    pop = 1'b1;
                    if (count_reg == 2'd2) begin
                        state_next    = L0;
                        out_data_next = mem[~rd_ptr_reg][7:0];
                    end else if (push) begin
                        // The only remaining group arrives on this very edge,
                        // so take its lane-0 byte straight from the inputs.
                        state_next    = L0;
                        out_data_next = in_data0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        out_valid_next = (state_next != IDLE);
    end

    // Occupancy update: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // State, pointers and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

`ifdef UNSTRIPE_SKEW_CHECK_EN
    logic skew_err_reg;
    logic partial;

    assign partial  = (|valids) & ~(&valids);
    assign skew_err = skew_err_reg;

    // Sticky skew flag: set on partial valids while ready, held until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            skew_err_reg <= 1'b0;
        else if (in_ready & partial)
            skew_err_reg <= 1'b1;
    end
`else
    assign skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_unstripe_4to1.sv
// Directed testbench for unstripe_4to1: single group, back-pressure, full
// FIFO, same-edge push/pop, skew detection and mid-operation reset.
module tb_unstripe_4to1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic       in_valid0, in_valid1, in_valid2, in_valid3;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       skew_err;

    int checks = 0;
    int errors = 0;

`ifdef UNSTRIPE_SKEW_CHECK_EN
    localparam logic EXP_SKEW = 1'b1;
`else
    localparam logic EXP_SKEW = 1'b0;
`endif

    unstripe_4to1 dut (
        .clk       (clk),
        .reset     (reset),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_valid0 (in_valid0),
        .in_valid1 (in_valid1),
        .in_valid2 (in_valid2),
        .in_valid3 (in_valid3),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .skew_err  (skew_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One line per observed output transaction, then compare it.
    task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
        $display("t=%0t %s out_valid=%0b out_data=%02h in_ready=%0b skew_err=%0b",
                 $time, tag, out_valid, out_data, in_ready, skew_err);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        if (v)
            chk({tag, ".data"}, out_data, d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_group(input logic [7:0] b0, b1, b2, b3);
        in_data0 = b0; in_data1 = b1; in_data2 = b2; in_data3 = b3;
        {in_valid3, in_valid2, in_valid1, in_valid0} = 4'b1111;
    endtask

    task automatic idle_in();
        {in_valid3, in_valid2, in_valid1, in_valid0} = 4'b0000;
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b1;
        in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
        idle_in();

        // Reset state
        #12;
        chk("rst.out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst.out_data", out_data, 8'h00);
        chk("rst.skew_err", {7'd0, skew_err}, 8'h00);
        chk("rst.in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        step();
        expect_out("post_rst", 1'b0, 8'h00);

        // Single group, one cycle of latency, four consecutive bytes
        drive_group(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step();
        idle_in();
        expect_out("single.accept", 1'b0, 8'h00);
        chk("single.in_ready", {7'd0, in_ready}, 8'h01);
        step(); expect_out("single.b0", 1'b1, 8'hA0);
        step(); expect_out("single.b1", 1'b1, 8'hA1);
        step(); expect_out("single.b2", 1'b1, 8'hA2);
        step(); expect_out("single.b3", 1'b1, 8'hA3);
        step(); expect_out("single.end", 1'b0, 8'h00);

        // Back-pressure during lane 1
        drive_group(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step();
        idle_in();
        step(); expect_out("bp.b0", 1'b1, 8'hA0);
        step(); expect_out("bp.b1", 1'b1, 8'hA1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("bp.hold", 1'b1, 8'hA1);
        end
        out_ready = 1'b1;
        step(); expect_out("bp.b2", 1'b1, 8'hA2);
        step(); expect_out("bp.b3", 1'b1, 8'hA3);
        step(); expect_out("bp.end", 1'b0, 8'h00);

        // Full FIFO: third group waits for the first group's pop
        out_ready = 1'b0;
        drive_group(8'h11, 8'h12, 8'h13, 8'h14);
        step();
        chk("full.rdy1", {7'd0, in_ready}, 8'h01);
        drive_group(8'h21, 8'h22, 8'h23, 8'h24);
        step();
        chk("full.rdy2", {7'd0, in_ready}, 8'h00);
        expect_out("full.g1b0", 1'b1, 8'h11);
        drive_group(8'h31, 8'h32, 8'h33, 8'h34);
        step();
        chk("full.rdy_wait", {7'd0, in_ready}, 8'h00);
        expect_out("full.g1hold", 1'b1, 8'h11);
        out_ready = 1'b1;
        step(); expect_out("full.g1b1", 1'b1, 8'h12);
        chk("full.rdy_l1", {7'd0, in_ready}, 8'h00);
        step(); expect_out("full.g1b2", 1'b1, 8'h13);
        step(); expect_out("full.g1b3", 1'b1, 8'h14);
        chk("full.rdy_l3", {7'd0, in_ready}, 8'h00);
        step(); expect_out("full.g2b0", 1'b1, 8'h21);
        chk("full.rdy_pop", {7'd0, in_ready}, 8'h01);
        step();
        idle_in();
        expect_out("full.g2b1", 1'b1, 8'h22);
        chk("full.rdy_g3in", {7'd0, in_ready}, 8'h00);
        step(); expect_out("full.g2b2", 1'b1, 8'h23);
        step(); expect_out("full.g2b3", 1'b1, 8'h24);
        step(); expect_out("full.g3b0", 1'b1, 8'h31);
        step(); expect_out("full.g3b1", 1'b1, 8'h32);
        step(); expect_out("full.g3b2", 1'b1, 8'h33);
        step(); expect_out("full.g3b3", 1'b1, 8'h34);
        step(); expect_out("full.end", 1'b0, 8'h00);

        // Same-edge push and pop: next group arrives on the L3 transfer edge
        drive_group(8'h51, 8'h52, 8'h53, 8'h54);
        step();
        idle_in();
        step(); expect_out("pp.e0", 1'b1, 8'h51);
        step(); expect_out("pp.e1", 1'b1, 8'h52);
        step(); expect_out("pp.e2", 1'b1, 8'h53);
        step(); expect_out("pp.e3", 1'b1, 8'h54);
        drive_group(8'h61, 8'h62, 8'h63, 8'h64);
        step();
        idle_in();
        expect_out("pp.f0", 1'b1, 8'h61);
        chk("pp.rdy", {7'd0, in_ready}, 8'h01);
        step(); expect_out("pp.f1", 1'b1, 8'h62);
        step(); expect_out("pp.f2", 1'b1, 8'h63);
        step(); expect_out("pp.f3", 1'b1, 8'h64);
        step(); expect_out("pp.end", 1'b0, 8'h00);

        // Skew: partial valids are never accepted
        in_data0 = 8'hEE; in_data1 = 8'hEE; in_data2 = 8'hEE; in_data3 = 8'hEE;
        {in_valid3, in_valid2, in_valid1, in_valid0} = 4'b0101;
        step();
        idle_in();
        chk("skew.flag", {7'd0, skew_err}, {7'd0, EXP_SKEW});
        chk("skew.rdy", {7'd0, in_ready}, 8'h01);
        step();
        expect_out("skew.noacc", 1'b0, 8'h00);
        step();
        chk("skew.sticky", {7'd0, skew_err}, {7'd0, EXP_SKEW});

        // Reset in the middle of a group
        drive_group(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        step();
        idle_in();
        step(); expect_out("mr.c0", 1'b1, 8'hC0);
        step(); expect_out("mr.c1", 1'b1, 8'hC1);
        step(); expect_out("mr.c2", 1'b1, 8'hC2);
        #2;
        reset = 1'b0;
        #1;
        chk("mr.out_valid", {7'd0, out_valid}, 8'h00);
        chk("mr.out_data", out_data, 8'h00);
        chk("mr.skew_err", {7'd0, skew_err}, 8'h00);
        chk("mr.in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        drive_group(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        step();
        idle_in();
        expect_out("mr.accept", 1'b0, 8'h00);
        step(); expect_out("mr.d0", 1'b1, 8'hD0);
        step(); expect_out("mr.d1", 1'b1, 8'hD1);
        step(); expect_out("mr.d2", 1'b1, 8'hD2);
        step(); expect_out("mr.d3", 1'b1, 8'hD3);
        step(); expect_out("mr.end", 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
